// File: rtl/mips_muldiv_if.sv
// mips_muldiv_if: request/result bundle between the execute stage and the multiply/divide unit
interface mips_muldiv_if;
  logic        start;
  logic [3:0]  AluOP;
  logic [31:0] X;
  logic [31:0] Y;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;
  modport master (output start, AluOP, X, Y, hi_we, lo_we, wdata, input busy, done, HI, LO);
  modport slave  (input start, AluOP, X, Y, hi_we, lo_we, wdata, output busy, done, HI, LO);
endinterface

// File: rtl/mips_muldiv.sv
// mips_muldiv: 32-cycle unsigned MULTU/DIVU unit with architectural HI/LO and MTHI/MTLO writes
// Ports: clk, rst_n (async active-low); bus.slave carries start/AluOP/X/Y requests,
// hi_we/lo_we/wdata writes, and busy/done/HI/LO results.
// MULDIV_DIV0_FAST_EN: DIVU by zero completes after a single cycle instead of 32.
module mips_muldiv (
  input logic clk,
  input logic rst_n,
  mips_muldiv_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [4:0] cnt;
  logic is_div, fast;
  logic [31:0] xr, yr, hi, lo, a, b, a_n, b_n;
  logic [32:0] sum, r_s;
  logic tneg, go, div0;
  assign go = state == IDLE && bus.start && (bus.AluOP == 4'd3 || bus.AluOP == 4'd4);
`ifdef MULDIV_DIV0_FAST_EN
  assign div0 = bus.AluOP == 4'd4 && bus.Y == 32'd0;
`else
  assign div0 = 1'b0;
`endif
  // a/b hold {P_hi,P_lo} for MULTU and {R,Q} for DIVU; a restored remainder is always below Y, so 32 bits suffice
  always_comb begin
    sum  = {1'b0, a} + (b[0] ? {1'b0, xr} : 33'd0);
    r_s  = {a, b[31]};
    tneg = r_s < {1'b0, yr};
    a_n  = is_div ? (tneg ? r_s[31:0] : r_s[31:0] - yr) : sum[32:1];
    b_n  = is_div ? {b[30:0], ~tneg} : {sum[0], b[31:1]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      fast   <= 1'b0;
      xr     <= '0;
      yr     <= '0;
      a      <= '0;
      b      <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (state == IDLE) begin
      if (go) begin
        state  <= RUN;
        cnt    <= div0 ? 5'd0 : 5'd31;
        is_div <= bus.AluOP == 4'd4;
        fast   <= div0;
        xr     <= bus.X;
        yr     <= bus.Y;
        a      <= '0;
        b      <= bus.AluOP == 4'd4 ? bus.X : bus.Y;
      end else begin
        if (bus.hi_we) hi <= bus.wdata;
        if (bus.lo_we) lo <= bus.wdata;
      end
    end else if (state == RUN) begin
      a   <= a_n;
      b   <= b_n;
      cnt <= cnt - 5'd1;
      if (cnt == 5'd0) begin
        state <= DONE;
        hi    <= fast ? xr : a_n;
        lo    <= fast ? 32'hFFFF_FFFF : b_n;
      end
    end else begin
      state <= IDLE;
    end
  end
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.HI   = hi;
  assign bus.LO   = lo;
endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv: randomized self-checking bench for mips_muldiv against an arithmetic reference model
module tb_mips_muldiv;
`ifdef MULDIV_DIV0_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  mips_muldiv_if bus ();
  mips_muldiv dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int rem;
  logic m_busy, m_done;
  logic [31:0] m_hi, m_lo, r_hi, r_lo;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= 0; m_busy <= 1'b0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0; r_hi <= '0; r_lo <= '0;
    end else if (m_done) begin
      m_done <= 1'b0; m_busy <= 1'b0;
    end else if (rem > 0) begin
      rem <= rem - 1;
      if (rem == 1) begin m_hi <= r_hi; m_lo <= r_lo; m_done <= 1'b1; end
    end else if (bus.start && (bus.AluOP == 4'd3 || bus.AluOP == 4'd4)) begin
      if (bus.AluOP == 4'd3) {r_hi, r_lo} <= 64'(bus.X) * 64'(bus.Y);
      else if (bus.Y == 0) begin r_hi <= bus.X; r_lo <= 32'hFFFF_FFFF; end
      else begin r_hi <= bus.X % bus.Y; r_lo <= bus.X / bus.Y; end
      rem <= (FAST && bus.AluOP == 4'd4 && bus.Y == 0) ? 1 : 32;
      m_busy <= 1'b1;
    end else begin
      if (bus.hi_we) m_hi <= bus.wdata;
      if (bus.lo_we) m_lo <= bus.wdata;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    chk("busy", 64'(bus.busy), 64'(m_busy));
    chk("done", 64'(bus.done), 64'(m_done));
    chk("HI", 64'(bus.HI), 64'(m_hi));
    chk("LO", 64'(bus.LO), 64'(m_lo));
    if (bus.done) done_cnt++;
  end

  task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic hw, input logic lw, input logic poke, input int exp_busy, input string nm);
    int nb, d0;
    nb = 0; d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.AluOP = op; bus.X = x; bus.Y = y;
    bus.hi_we = hw; bus.lo_we = lw; bus.wdata = $urandom;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    bus.X = $urandom; bus.Y = $urandom; bus.AluOP = 4'($urandom);
    while (bus.busy && nb < 100) begin
      nb++;
      if (poke && nb == 5) begin
        bus.start = 1'b1; bus.AluOP = 4'd3; bus.X = 2; bus.Y = 3; bus.hi_we = 1'b1; bus.wdata = 5;
      end else begin
        bus.start = 1'b0; bus.hi_we = 1'b0;
      end
      @(negedge clk);
    end
    chk({nm, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
    chk({nm, "_done_pulses"}, 64'(done_cnt - d0), 64'(exp_busy > 0));
  endtask

  task automatic idle_write(input logic hw, input logic lw, input logic [31:0] d);
    @(negedge clk);
    bus.hi_we = hw; bus.lo_we = lw; bus.wdata = d;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
  endtask

  initial begin
    int d0;
    bus.start = 1'b0; bus.AluOP = '0; bus.X = '0; bus.Y = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_HI", 64'(bus.HI), 64'd0);
    chk("rst_LO", 64'(bus.LO), 64'd0);
    #1 rst_n = 1'b1;

    do_op(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 33, "mul_max");
    chk("mul_max_HI", 64'(bus.HI), 64'h0000_0000_FFFF_FFFE);
    chk("mul_max_LO", 64'(bus.LO), 64'h0000_0000_0000_0001);

    do_op(4'd4, 32'd100, 32'd7, 1'b0, 1'b0, 1'b1, 33, "div_100_7");
    chk("div_100_7_LO", 64'(bus.LO), 64'd14);
    chk("div_100_7_HI", 64'(bus.HI), 64'd2);

    do_op(4'd4, 32'h8000_0000, 32'd3, 1'b1, 1'b1, 1'b0, 33, "div_big_3");
    chk("div_big_3_LO", 64'(bus.LO), 64'h2AAA_AAAA);
    chk("div_big_3_HI", 64'(bus.HI), 64'd2);

    idle_write(1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("mthi_HI", 64'(bus.HI), 64'hDEAD_BEEF);
    chk("mthi_LO", 64'(bus.LO), 64'h2AAA_AAAA);

    do_op(4'd5, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0, 0, "bad_op");
    chk("bad_op_HI", 64'(bus.HI), 64'hDEAD_BEEF);

    do_op(4'd4, 32'h1234, 32'd0, 1'b0, 1'b0, 1'b0, FAST ? 2 : 33, "div0");
    chk("div0_LO", 64'(bus.LO), 64'hFFFF_FFFF);
    chk("div0_HI", 64'(bus.HI), 64'h1234);

    idle_write(1'b1, 1'b1, 32'h55);
    chk("mthilo_HI", 64'(bus.HI), 64'h55);
    chk("mthilo_LO", 64'(bus.LO), 64'h55);

    for (int i = 0; i < 25; i++) begin
      int k;
      logic [31:0] x, y;
      logic [3:0] op;
      k = $urandom_range(0, 5);
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
      if (k == 5) idle_write(1'($urandom), 1'($urandom), $urandom);
      else begin
        op = k < 2 ? 4'd3 : k < 4 ? 4'd4 : 4'(5 + $urandom_range(0, 10));
        do_op(op, x, y, 1'($urandom), 1'($urandom), 1'($urandom),
              op == 4'd3 ? 33 : op == 4'd4 ? ((FAST && y == 0) ? 2 : 33) : 0, "rnd");
      end
    end

    d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.AluOP = 4'd3; bus.X = 32'hFFFF; bus.Y = 32'hFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_HI", 64'(bus.HI), 64'd0);
    chk("arst_LO", 64'(bus.LO), 64'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_no_done", 64'(done_cnt - d0), 64'd0);

    do_op(4'd3, 32'd6, 32'd7, 1'b0, 1'b0, 1'b0, 33, "mul_6_7");
    chk("mul_6_7_LO", 64'(bus.LO), 64'd42);
    chk("mul_6_7_HI", 64'(bus.HI), 64'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
